// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: state encoding, default widths and
// the memory-op decode helper.
package mem_wb_stage_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int RA_W_DEF    = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  function automatic logic is_memop(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: IDLE/ACCESS FSM, watchdog timer, dmem drive and
// the combinational stall back to EX/MEM.
module mem_access_ctrl
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              flush,
  input  logic              overflow,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              stall,
  output logic              wb_load,
  output logic              from_mem,
  output logic              abort,
  output logic              ovf_hit
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                live;
  logic                accept;
  logic                timeout_hit;

  assign live        = valid & ~flush;
  assign accept      = live & ~overflow;
  assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    stall    = 1'b0;
    wb_load  = 1'b0;
    from_mem = 1'b0;
    abort    = 1'b0;
    ovf_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        ovf_hit = live & overflow;
        if (accept && is_memop(mem_read, mem_write)) begin
          stall   = 1'b1;
          we_d    = mem_write;
          addr_d  = addr_in;
          wdata_d = wdata_in;
          timer_d = '0;
          state_d = ACCESS;
        end else begin
          wb_load = accept;
        end
      end
      ACCESS: begin
        // An ack on the last allowed cycle still completes the access.
        if (dmem_ack) begin
          wb_load  = 1'b1;
          from_mem = 1'b1;
          timer_d  = '0;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          stall   = 1'b1;
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage top: drives the data-memory access and holds the MEM/WB register
// with the writeback data mux.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RA_W    = RA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_MEM,
  input  logic              flush_MEM,
  input  logic [DATA_W-1:0] ALUResult_MEM,
  input  logic [DATA_W-1:0] R0D_MEM,
  input  logic [DATA_W-1:0] DataIn_MEM,
  input  logic [RA_W-1:0]   RA1_MEM,
  input  logic [3:0]        opcode_MEM,
  input  logic              regWrite_MEM,
  input  logic              r0Write_MEM,
  input  logic              memRead_MEM,
  input  logic              memWrite_MEM,
  input  logic              memSource_MEM,
  input  logic              overflow_MEM,
  output logic              stall_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              valid_WB,
  output logic              regWrite_WB,
  output logic              r0Write_WB,
  output logic [RA_W-1:0]   RA1_WB,
  output logic [DATA_W-1:0] WriteData_WB,
  output logic [DATA_W-1:0] R0D_WB,
  output logic [3:0]        opcode_WB,
  output logic              ovf_exc,
  output logic              mem_fault
);

  logic wb_load, from_mem, abort, ovf_hit;

  mem_access_ctrl #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid_MEM),
    .flush      (flush_MEM),
    .overflow   (overflow_MEM),
    .mem_read   (memRead_MEM),
    .mem_write  (memWrite_MEM),
    .addr_in    (ALUResult_MEM),
    .wdata_in   (DataIn_MEM),
    .dmem_ack   (dmem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .stall      (stall_MEM),
    .wb_load    (wb_load),
    .from_mem   (from_mem),
    .abort      (abort),
    .ovf_hit    (ovf_hit)
  );

  logic              valid_wb_q, valid_wb_d;
  logic              reg_write_wb_q, reg_write_wb_d;
  logic              r0_write_wb_q, r0_write_wb_d;
  logic [RA_W-1:0]   ra1_wb_q, ra1_wb_d;
  logic [DATA_W-1:0] write_data_wb_q, write_data_wb_d;
  logic [DATA_W-1:0] r0d_wb_q, r0d_wb_d;
  logic [3:0]        opcode_wb_q, opcode_wb_d;
  logic              ovf_exc_q, ovf_exc_d;
  logic              mem_fault_q, mem_fault_d;

  // Bubbles clear only the write enables; the data fields keep their last value.
  always_comb begin
    valid_wb_d      = wb_load;
    reg_write_wb_d  = wb_load & regWrite_MEM;
    r0_write_wb_d   = wb_load & r0Write_MEM;
    ra1_wb_d        = ra1_wb_q;
    write_data_wb_d = write_data_wb_q;
    r0d_wb_d        = r0d_wb_q;
    opcode_wb_d     = opcode_wb_q;
    ovf_exc_d       = ovf_hit;
    mem_fault_d     = abort;
    if (wb_load) begin
      ra1_wb_d        = RA1_MEM;
      write_data_wb_d = (from_mem && memSource_MEM) ? dmem_rdata : ALUResult_MEM;
      r0d_wb_d        = R0D_MEM;
      opcode_wb_d     = opcode_MEM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_wb_q      <= 1'b0;
      reg_write_wb_q  <= 1'b0;
      r0_write_wb_q   <= 1'b0;
      ra1_wb_q        <= '0;
      write_data_wb_q <= '0;
      r0d_wb_q        <= '0;
      opcode_wb_q     <= '0;
      ovf_exc_q       <= 1'b0;
      mem_fault_q     <= 1'b0;
    end else begin
      valid_wb_q      <= valid_wb_d;
      reg_write_wb_q  <= reg_write_wb_d;
      r0_write_wb_q   <= r0_write_wb_d;
      ra1_wb_q        <= ra1_wb_d;
      write_data_wb_q <= write_data_wb_d;
      r0d_wb_q        <= r0d_wb_d;
      opcode_wb_q     <= opcode_wb_d;
      ovf_exc_q       <= ovf_exc_d;
      mem_fault_q     <= mem_fault_d;
    end
  end

  assign valid_WB     = valid_wb_q;
  assign regWrite_WB  = reg_write_wb_q;
  assign r0Write_WB   = r0_write_wb_q;
  assign RA1_WB       = ra1_wb_q;
  assign WriteData_WB = write_data_wb_q;
  assign R0D_WB       = r0d_wb_q;
  assign opcode_WB    = opcode_wb_q;
  assign ovf_exc      = ovf_exc_q;
  assign mem_fault    = mem_fault_q;

endmodule
